// File: rtl/wr_collector_pkg.sv
// Shared types and widths for the worker-result collector.
package wr_collector_pkg;

    localparam int unsigned DEST_OPTION_WIDTH   = 3;
    localparam int unsigned DEST_ADDR_WIDTH     = 16;
    localparam int unsigned COLOR_WIDTH         = 16;
    localparam int unsigned DATA_WIDTH          = 32;
    localparam int unsigned WORKER_RESULT_WIDTH =
        DEST_OPTION_WIDTH + DEST_ADDR_WIDTH + COLOR_WIDTH + DATA_WIDTH;

    // Field layout of one result word, MSB first.
    typedef struct packed {
        logic [DEST_OPTION_WIDTH-1:0] dest_option;
        logic [DEST_ADDR_WIDTH-1:0]   dest_addr;
        logic [COLOR_WIDTH-1:0]       color;
        logic [DATA_WIDTH-1:0]        data;
    } worker_result_t;

    // Pack the four fields into one result word.
    function automatic logic [WORKER_RESULT_WIDTH-1:0] make_worker_result(
        input logic [DEST_OPTION_WIDTH-1:0] dest_option,
        input logic [DEST_ADDR_WIDTH-1:0]   dest_addr,
        input logic [COLOR_WIDTH-1:0]       color,
        input logic [DATA_WIDTH-1:0]        data
    );
        worker_result_t r;
        r.dest_option = dest_option;
        r.dest_addr   = dest_addr;
        r.color       = color;
        r.data        = data;
        return r;
    endfunction

    // Next round-robin position after granting idx, modulo n.
    function automatic int unsigned rr_advance(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO with valid/ready on both sides; head is read straight from storage.
module wr_fifo #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             push_valid_i,
    output logic                             push_ready_o,
    input  logic [WIDTH-1:0]                 push_data_i,
    output logic                             pop_valid_o,
    input  logic                             pop_ready_i,
    output logic [WIDTH-1:0]                 pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o,
    output logic                             full_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    // Status and handshakes; no full-bypass, so a full FIFO never accepts.
    always_comb begin
        full_o       = (count_q == CNT_W'(DEPTH));
        push_ready_o = !full_o && !rst_i;
        pop_valid_o  = (count_q != '0);
        pop_data_o   = mem_q[rptr_q];
        count_o      = count_q;
        push         = push_valid_i && push_ready_o;
        pop          = pop_valid_o && pop_ready_i;
    end

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ADDR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/wr_collector.sv
// Round-robin merge of worker results into one buffered, ordered stream.
module wr_collector
    import wr_collector_pkg::*;
#(
    parameter int unsigned NUM_WORKERS         = 4,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter int unsigned WORKER_RESULT_WIDTH = wr_collector_pkg::WORKER_RESULT_WIDTH
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic [NUM_WORKERS-1:0]                     RECEIVE_WR_VALID,
    input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] RECEIVE_WR_DATA,
    output logic [NUM_WORKERS-1:0]                     RECEIVE_WR_READY,
    output logic                                       SEND_WR_VALID,
    output logic [WORKER_RESULT_WIDTH-1:0]             SEND_WR_DATA,
    input  logic                                       SEND_WR_READY
);

    localparam int unsigned W     = WORKER_RESULT_WIDTH;
    localparam int unsigned RR_W  = $clog2(NUM_WORKERS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [RR_W-1:0]  rr_q, rr_d;
    logic             found;
    logic [RR_W-1:0]  grant_idx;
    int unsigned      scan_idx;
    logic [W-1:0]     grant_data;
    logic             fifo_push_ready;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic             push;

    // Scan from rr upward (modulo NUM_WORKERS); first valid worker wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            scan_idx = (32'(rr_q) + i) % NUM_WORKERS;
            if (!found && RECEIVE_WR_VALID[RR_W'(scan_idx)]) begin
                found     = 1'b1;
                grant_idx = RR_W'(scan_idx);
            end
        end
    end

    // Select the granted worker's slice.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            if (grant_idx == RR_W'(i)) begin
                grant_data = RECEIVE_WR_DATA[i*W +: W];
            end
        end
    end

    // READY only to the granted worker, only when the FIFO can take it (FIFO gates on RST).
    always_comb begin
        RECEIVE_WR_READY = '0;
        push             = found && fifo_push_ready;
        if (push) begin
            RECEIVE_WR_READY[grant_idx] = 1'b1;
        end
    end

    // Pointer moves past the winner on a push, otherwise holds.
    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = RR_W'(rr_advance(32'(grant_idx), NUM_WORKERS));
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    wr_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (CLK),
        .rst_i        (RST),
        .push_valid_i (found),
        .push_ready_o (fifo_push_ready),
        .push_data_i  (grant_data),
        .pop_valid_o  (SEND_WR_VALID),
        .pop_ready_i  (SEND_WR_READY),
        .pop_data_o   (SEND_WR_DATA),
        .count_o      (fifo_count),
        .full_o       (fifo_full)
    );

    // Occupancy sanity: never beyond depth, and a full FIFO never advertises space.
    a_count_range : assert property (@(posedge CLK) disable iff (RST)
        32'(fifo_count) <= FIFO_DEPTH);
    a_full_blocks : assert property (@(posedge CLK) disable iff (RST)
        fifo_full |-> !fifo_push_ready);

endmodule

// File: tb/tb_wr_collector.sv
// Directed bench for wr_collector with a queue-based scoreboard and round-robin model.
module tb_wr_collector;
    import wr_collector_pkg::*;

    localparam int unsigned NW = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned W  = WORKER_RESULT_WIDTH;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NW-1:0]     RECEIVE_WR_VALID;
    logic [NW*W-1:0]   RECEIVE_WR_DATA;
    logic [NW-1:0]     RECEIVE_WR_READY;
    logic              SEND_WR_VALID;
    logic [W-1:0]      SEND_WR_DATA;
    logic              SEND_WR_READY;

    logic [W-1:0]      wdata [NW];
    logic [W-1:0]      q [$];
    int unsigned       rr_m;
    int                n_cmp  = 0;
    int                n_fail = 0;
    int                n_acc_obs = 0;
    bit                auto_inc = 0;
    bit                fair_chk = 0;
    int                fair_cnt = 0;

    wr_collector #(
        .NUM_WORKERS         (NW),
        .FIFO_DEPTH          (FD),
        .WORKER_RESULT_WIDTH (W)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .RECEIVE_WR_VALID (RECEIVE_WR_VALID),
        .RECEIVE_WR_DATA  (RECEIVE_WR_DATA),
        .RECEIVE_WR_READY (RECEIVE_WR_READY),
        .SEND_WR_VALID    (SEND_WR_VALID),
        .SEND_WR_DATA     (SEND_WR_DATA),
        .SEND_WR_READY    (SEND_WR_READY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        RECEIVE_WR_DATA = '0;
        for (int i = 0; i < NW; i++) RECEIVE_WR_DATA[i*W +: W] = wdata[i];
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pred_grant();
        for (int i = 0; i < NW; i++) begin
            int idx;
            idx = int'((rr_m + i) % NW);
            if (RECEIVE_WR_VALID[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock cycle: entered and left at a falling edge with inputs already driven.
    task automatic step();
        int            g;
        logic [NW-1:0] exp_rdy;
        bit            push;
        logic [W-1:0]  popped;
        #2;
        g = RST ? -1 : pred_grant();
        exp_rdy = '0;
        if (g >= 0 && q.size() < FD) exp_rdy[g] = 1'b1;
        chk("recv_ready", W'(RECEIVE_WR_READY), W'(exp_rdy));
        chk("send_valid", W'(SEND_WR_VALID), W'(q.size() != 0));
        if (|RECEIVE_WR_READY) n_acc_obs++;
        if (q.size() != 0) begin
            chk("send_data", SEND_WR_DATA, q[0]);
            if (SEND_WR_READY) begin
                if (fair_chk) begin
                    chk("fair_order", W'(SEND_WR_DATA[7:0]), W'(fair_cnt % NW));
                    fair_cnt++;
                end
                popped = q.pop_front();
            end
        end
        push = (exp_rdy != '0);
        if (push) begin
            q.push_back(wdata[g]);
            rr_m = (g + 1) % NW;
        end
        @(posedge CLK);
        #1;
        if (push && auto_inc) wdata[g] = wdata[g] + 1;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        q.delete();
        rr_m = 0;
        repeat (2) step();
        RST = 1'b0;
    endtask

    int acc0;
    logic [W-1:0] word;

    initial begin
        RST              = 1'b1;
        RECEIVE_WR_VALID = '1;
        SEND_WR_READY    = 1'b0;
        for (int i = 0; i < NW; i++) wdata[i] = W'(i);
        rr_m = 0;
        @(negedge CLK);

        // Reset holds everything quiet even with all workers valid; worker 0 wins first.
        do_reset();
        #1 chk("first_grant", W'(RECEIVE_WR_READY), W'(4'b0001));
        step();
        RECEIVE_WR_VALID = '0;
        SEND_WR_READY    = 1'b1;
        repeat (3) step();

        // Single result from worker 2 appears one cycle after acceptance.
        word = make_worker_result(3'b010, 16'hdead, 16'h0f0f, 32'hdeadbeef);
        wdata[2] = word;
        RECEIVE_WR_VALID = 4'b0100;
        step();
        RECEIVE_WR_VALID = '0;
        #1 chk("single_word", SEND_WR_DATA, word);
        chk("single_valid", W'(SEND_WR_VALID), W'(1));
        step();
        step();

        // Fairness: data = worker index, outputs cycle 0,1,2,3.
        for (int i = 0; i < NW; i++) wdata[i] = W'(i);
        RECEIVE_WR_VALID = '1;
        do_reset();
        fair_chk = 1;
        fair_cnt = 0;
        repeat (12) step();
        fair_chk = 0;

        // Back-pressure: exactly FD accepted, then nothing until drained.
        do_reset();
        SEND_WR_READY = 1'b0;
        acc0 = n_acc_obs;
        repeat (7) step();
        chk("bp_accepted", W'(n_acc_obs - acc0), W'(FD));
        SEND_WR_READY = 1'b1;
        repeat (8) step();

        // Simultaneous push and pop at occupancy 2.
        for (int i = 0; i < NW; i++) wdata[i] = W'(i << 8);
        auto_inc = 1;
        RECEIVE_WR_VALID = 4'b0001;
        do_reset();
        SEND_WR_READY = 1'b0;
        repeat (2) step();
        chk("fill_count", W'(dut.u_fifo.count_o), W'(2));
        RECEIVE_WR_VALID = '1;
        SEND_WR_READY    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("steady_count", W'(dut.u_fifo.count_o), W'(2));
        end

        // Mid-operation reset with three entries buffered.
        SEND_WR_READY    = 1'b0;
        RECEIVE_WR_VALID = 4'b0010;
        step();
        RECEIVE_WR_VALID = 4'b1111;
        #3 RST = 1'b1;
        #1 chk("rst_send_valid", W'(SEND_WR_VALID), W'(0));
        chk("rst_recv_ready", W'(RECEIVE_WR_READY), W'(0));
        @(negedge CLK);
        q.delete();
        rr_m = 0;
        step();
        RECEIVE_WR_VALID = '0;
        SEND_WR_READY    = 1'b1;
        RST              = 1'b0;
        repeat (3) step();
        auto_inc = 0;
        wdata[1] = make_worker_result(3'b101, 16'h1234, 16'habcd, 32'h0badf00d);
        RECEIVE_WR_VALID = 4'b0010;
        step();
        RECEIVE_WR_VALID = '0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_collector.md
# wr_collector

Collects worker results from `NUM_WORKERS` parallel `worker` instances and merges them into one ordered stream toward the matching stage. Each accepted result carries `{dest_option, dest_addr, color, data}`. The block uses one-per-cycle round-robin arbitration and buffers accepted results in a small FIFO, so a stalled matching stage back-pressures the workers without losing tokens. It sits directly downstream of the workers' `SEND_WR` ports.

## Interface
- `NUM_WORKERS`, 4: number of worker result inputs; must be 2..8.
- `FIFO_DEPTH`, 4: result buffer entries; must be a power of two, at least 2.
- `WORKER_RESULT_WIDTH`, from `include/param.vh` (67): `{dest_option[2:0], dest_addr[15:0], color[15:0], data[31:0]}`, MSB first.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous and active-high.
- `RECEIVE_WR_VALID`  in  NUM_WORKERS  per-worker result valid.
- `RECEIVE_WR_DATA`  in  NUM_WORKERS*WORKER_RESULT_WIDTH  worker i occupies slice `[i*W +: W]`.
- `RECEIVE_WR_READY`  out  NUM_WORKERS  per-worker accept; one-hot or zero.
- `SEND_WR_VALID`  out  1  head of FIFO valid.
- `SEND_WR_DATA`  out  WORKER_RESULT_WIDTH  head of FIFO.
- `SEND_WR_READY`  in  1  downstream accept.

## Operation
- Transfer on any channel occurs when VALID and READY are both high at a rising edge. Sources hold VALID and DATA stable until the transfer.
- State:
  - round-robin pointer `rr`, range 0..NUM_WORKERS-1.
  - FIFO storage, with read pointer, write pointer and `count` (range 0..FIFO_DEPTH).
- Grant: scan workers `rr`, `rr+1`, … modulo NUM_WORKERS. The first with VALID high is granted.
- `RECEIVE_WR_READY[g]` = grant to g AND `count < FIFO_DEPTH` AND NOT `RST`. READY depends combinationally on VALID, which is legal on the receiving side. All other READY bits are 0.
- On a push, `rr` becomes g+1 modulo NUM_WORKERS. Without a push, `rr` holds.
- `SEND_WR_VALID` = `count != 0`. `SEND_WR_DATA` = entry at the read pointer, driven directly from storage with no extra register.
- Pop = `SEND_WR_VALID` AND `SEND_WR_READY`.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both: unchanged, both pointers advance.
- Full (`count == FIFO_DEPTH`): no READY is asserted, even if a pop happens in the same cycle. There is no full-bypass.
- Empty: `SEND_WR_VALID` is 0. There is no input-to-output combinational bypass.
- Pointers wrap modulo FIFO_DEPTH.
- Data passes through bit-exact. The block never inspects or modifies `dest_option`, `color` or `data`.
- Ordering:
  - results from one worker leave in acceptance order.
  - across workers, results leave in grant order.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - `count`, both pointers and `rr` go to 0.
  - `SEND_WR_VALID` = 0 and `RECEIVE_WR_READY` = 0 while `RST` is high.
- Reset mid-operation discards all buffered results. A worker transfer in flight when reset asserts is not accepted.
- Latency: a result accepted at edge N is visible on `SEND_WR_*` after edge N (cycle N+1) when the FIFO was empty. Otherwise it appears after all earlier entries.
- Throughput: one result accepted and one emitted per cycle in steady state.
- Starvation bound: a continuously valid worker is granted within NUM_WORKERS pushes.

## Structure
- Shared `include/param.vh` holds:
  - `WORKER_RESULT_WIDTH`.
  - field widths for dest option, dest addr, color and data.
- `make_worker_result` stays in `include/construct.vh` for benches.
- One natural sub-module: `wr_fifo`, a parameterized synchronous FIFO with valid/ready on both sides, count and full flag.
- `wr_collector` itself contains the round-robin arbiter and slice mux.

## Test plan
- Reset: `RST`=1 with all VALID=1 -> `RECEIVE_WR_READY`=0 and `SEND_WR_VALID`=0. After `RST`=0, worker 0 is granted first.
- Single result: worker 2 sends `{3'b010, 16'hdead, 16'h0f0f, 32'hdeadbeef}`, `SEND_WR_READY`=1 -> identical word appears on `SEND_WR_DATA` one cycle later.
- Fairness: all 4 workers hold VALID with data = worker index -> outputs are 0,1,2,3,0,1,… with no worker granted twice in 4 pushes.
- Back-pressure/full:
  - hold `SEND_WR_READY`=0 with 4 workers valid -> exactly 4 accepted, then all READY = 0.
  - release -> 4 results drain in grant order, and accepts resume.
- Simultaneous push and pop with `count`=2 and READY high both sides for 20 cycles -> `count` stays 2, no loss or duplication, scoreboard matches.
- Mid-operation reset: pulse `RST` with 3 buffered entries -> `SEND_WR_VALID` drops immediately (asynchronous) and nothing stale is emitted after release.
